// File: rtl/usb_dac_loader.sv
// Host-loaded waveform player: FT245 bytes fill a 1024x12 RAM, then the RAM is
// replayed cyclically to a 12-bit parallel DAC with a programmable DAC clock.
module usb_dac_loader #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter logic [ADDR_WIDTH-1:0] SAMPLE_LAST = ADDR_WIDTH'(1023),
    parameter logic [23:0]           TIMEOUT_CYC = 24'd10_000_000,
    parameter logic [3:0]            DIV_RESET   = 4'd3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX_DONE,
    input  logic [7:0]  RX_DATA,
    input  logic        TX_VALID,
    input  logic        TX_DONE,
    output logic        TXEN,
    output logic [7:0]  TX_DATA,
    output logic        DAC_CLK,
    output logic [11:0] DAC_DATA,
    output logic        PLAYING,
    output logic        LOADED
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_L, S_LOAD_H, S_TX_WAIT, S_TX_DONE_W
    } state_t;

    localparam logic [3:0]  OP_LOAD  = 4'd1;
    localparam logic [3:0]  OP_POLL  = 4'd2;
    localparam logic [3:0]  OP_PLAY  = 4'd3;
    localparam logic [3:0]  OP_DIV   = 4'd4;
    localparam logic [3:0]  OP_STOP  = 4'd5;
    localparam logic [11:0] MIDSCALE = 12'h800;

    state_t                r_state, w_next;

    logic                  r_txen;
    logic [7:0]            r_tx_data;
    logic                  r_loaded;
    logic [3:0]            r_div;
    logic [ADDR_WIDTH-1:0] r_ld_addr;
    logic [7:0]            r_low;
    logic [23:0]           r_tmo;

    logic                  r_playing;
    logic                  r_dac_clk;
    logic [3:0]            r_div_cnt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [11:0]           r_rd_q;
    logic [11:0]           r_dac_data;
    logic [11:0]           r_ram [0:(1<<ADDR_WIDTH)-1];

    logic       w_cmd_vld, w_load_go, w_play_go, w_stop, w_div_we;
    logic       w_low_we, w_ram_we, w_load_done, w_tmo_run, w_tmo_abort;
    logic       w_tx_req, w_tx_fire;
    logic [7:0] w_tx_byte;
    logic       w_tmo;

    assign w_tmo = (r_tmo >= TIMEOUT_CYC);

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (RX_DONE) begin
                    case (RX_DATA[3:0])
                        OP_LOAD: w_next = S_LOAD_L;
                        OP_POLL: w_next = S_TX_WAIT;
                        OP_PLAY: if (!r_loaded) w_next = S_TX_WAIT;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_LOAD_L: begin
                if (RX_DONE)    w_next = S_LOAD_H;
                else if (w_tmo) w_next = S_TX_WAIT;
            end
            S_LOAD_H: begin
                if (RX_DONE)    w_next = (r_ld_addr == SAMPLE_LAST) ? S_TX_WAIT : S_LOAD_L;
                else if (w_tmo) w_next = S_TX_WAIT;
            end
            S_TX_WAIT:   if (!TX_VALID) w_next = S_TX_DONE_W;
            S_TX_DONE_W: if (TX_DONE)   w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Control strobes for the datapath; RX bytes outside IDLE/LOAD are never consumed.
    always_comb begin
        w_cmd_vld   = (r_state == S_IDLE) && RX_DONE;
        w_load_go   = w_cmd_vld && (RX_DATA[3:0] == OP_LOAD);
        w_play_go   = w_cmd_vld && (RX_DATA[3:0] == OP_PLAY) && r_loaded;
        w_stop      = w_cmd_vld && ((RX_DATA[3:0] == OP_STOP) || (RX_DATA[3:0] == OP_LOAD));
        w_div_we    = w_cmd_vld && (RX_DATA[3:0] == OP_DIV);
        w_low_we    = (r_state == S_LOAD_L) && RX_DONE;
        w_ram_we    = (r_state == S_LOAD_H) && RX_DONE;
        w_load_done = w_ram_we && (r_ld_addr == SAMPLE_LAST);
        w_tmo_run   = (r_state == S_LOAD_L) || (r_state == S_LOAD_H);
        w_tmo_abort = w_tmo_run && !RX_DONE && w_tmo;
        w_tx_fire   = (r_state == S_TX_WAIT) && !TX_VALID;
        w_tx_req    = 1'b0;
        w_tx_byte   = 8'hEE;
        if (w_cmd_vld && (RX_DATA[3:0] == OP_POLL)) begin
            w_tx_req  = 1'b1;
            w_tx_byte = {4'h5, 2'b00, r_loaded, r_playing};
        end else if (w_cmd_vld && (RX_DATA[3:0] == OP_PLAY) && !r_loaded) begin
            w_tx_req  = 1'b1;
        end else if (w_load_done) begin
            w_tx_req  = 1'b1;
            w_tx_byte = 8'hA5;
        end else if (w_tmo_abort) begin
            w_tx_req  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_txen    <= 1'b0;
            r_tx_data <= 8'h00;
            r_loaded  <= 1'b0;
            r_div     <= DIV_RESET;
            r_ld_addr <= '0;
            r_low     <= 8'h00;
            r_tmo     <= 24'd0;
        end else begin
            r_txen <= w_tx_fire;
            if (w_tx_req) r_tx_data <= w_tx_byte;
            if (w_div_we) r_div <= RX_DATA[7:4];
            if (w_low_we) r_low <= RX_DATA;
            if (w_load_go) begin
                r_loaded  <= 1'b0;
                r_ld_addr <= '0;
                r_tmo     <= 24'd0;
            end else if (w_tmo_run) begin
                r_tmo <= RX_DONE ? 24'd0 : r_tmo + 24'd1;
            end
            if (w_ram_we && !w_load_done) r_ld_addr <= r_ld_addr + ADDR_WIDTH'(1);
            if (w_load_done) r_loaded <= 1'b1;
        end
    end

    // Waveform RAM: no reset so it maps onto block RAM; read port doubles as prefetch.
    always_ff @(posedge CLK) begin
        if (w_ram_we) r_ram[r_ld_addr] <= {RX_DATA[3:0], r_low};
        r_rd_q <= r_ram[r_rd_addr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_playing  <= 1'b0;
            r_dac_clk  <= 1'b0;
            r_div_cnt  <= 4'd0;
            r_rd_addr  <= '0;
            r_dac_data <= MIDSCALE;
        end else if (w_stop) begin
            r_playing  <= 1'b0;
            r_dac_clk  <= 1'b0;
            r_div_cnt  <= 4'd0;
            r_dac_data <= MIDSCALE;
        end else if (w_play_go) begin
            r_playing  <= 1'b1;
            r_dac_clk  <= 1'b0;
            r_div_cnt  <= 4'd0;
            r_rd_addr  <= '0;
        end else if (!r_playing) begin
            r_dac_clk  <= 1'b0;
            r_div_cnt  <= 4'd0;
        end else if (r_div_cnt == r_div) begin
            r_dac_clk <= ~r_dac_clk;
            r_div_cnt <= 4'd0;
            if (r_dac_clk) begin
                r_dac_data <= r_rd_q;
                r_rd_addr  <= (r_rd_addr == SAMPLE_LAST) ? '0 : r_rd_addr + ADDR_WIDTH'(1);
            end
        end else if (r_div_cnt > r_div) begin
            r_div_cnt <= 4'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
        end
    end

    assign TXEN     = r_txen;
    assign TX_DATA  = r_tx_data;
    assign DAC_CLK  = r_dac_clk;
    assign DAC_DATA = r_dac_data;
    assign PLAYING  = r_playing;
    assign LOADED   = r_loaded;

endmodule

// File: tb/tb_usb_dac_loader.sv
// Bench for usb_dac_loader: command table, TX/DAC scoreboards, load/replay/timeout/handshake sequences.
module tb_usb_dac_loader;

    logic        CLK;
    logic        RST;
    logic        RX_DONE;
    logic [7:0]  RX_DATA;
    logic        TX_VALID;
    logic        TX_DONE;
    logic        TXEN;
    logic [7:0]  TX_DATA;
    logic        DAC_CLK;
    logic [11:0] DAC_DATA;
    logic        PLAYING;
    logic        LOADED;

    usb_dac_loader #(.TIMEOUT_CYC(24'd300)) dut (
        .CLK(CLK), .RST(RST), .RX_DONE(RX_DONE), .RX_DATA(RX_DATA),
        .TX_VALID(TX_VALID), .TX_DONE(TX_DONE), .TXEN(TXEN), .TX_DATA(TX_DATA),
        .DAC_CLK(DAC_CLK), .DAC_DATA(DAC_DATA), .PLAYING(PLAYING), .LOADED(LOADED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] cmd;
        bit         has_resp;
        logic [7:0] resp;
        bit         exp_play;
        bit         exp_loaded;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          tx_seen = 0;
    logic [7:0]  txq[$];
    logic [11:0] dacq[$];
    bit          tx_auto = 1'b1;
    bit          force_done = 1'b0;
    int          mon_mode = 0;
    bit          mon_fresh = 1'b0;
    int          exp_period = 2;
    int          rise_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA = b;
        RX_DONE = 1'b1;
        @(negedge CLK);
        RX_DONE = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int k = 0;
        while (txq.size() != 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, "_tx_pending"}, txq.size(), 0);
        txq.delete();
    endtask

    task automatic do_load();
        send_byte(8'h01);
        for (int i = 0; i < 1024; i++) begin
            logic [11:0] s;
            s = 12'(i);
            send_byte(s[7:0]);
            if (i == 1023) txq.push_back(8'hA5);
            send_byte({4'hA, s[11:8]});    // junk upper nibble must be ignored
        end
        wait_drain(100, "load");
        repeat (10) @(negedge CLK);
        chk("load_loaded", LOADED, 1);
        chk("load_playing", PLAYING, 0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_txen"}, TXEN, 0);
        chk({nm, "_txdata"}, TX_DATA, 0);
        chk({nm, "_dacclk"}, DAC_CLK, 0);
        chk({nm, "_dacdata"}, DAC_DATA, 12'h800);
        chk({nm, "_playing"}, PLAYING, 0);
        chk({nm, "_loaded"}, LOADED, 0);
    endtask

    initial forever @(posedge CLK) cyc++;

    // TX scoreboard: every TXEN pops one expected byte.
    initial forever begin
        @(negedge CLK);
        if (TXEN) begin
            tx_seen++;
            chk("txen_while_busy", TX_VALID, 0);
            if (txq.size() == 0) chk("tx_unexpected", {24'd0, TX_DATA}, 32'hFFFF_FFFF);
            else chk("tx_byte", TX_DATA, txq.pop_front());
        end
    end

    // Host-side TX_DONE model.
    initial begin
        int done_cnt = 0;
        TX_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            TX_DONE = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) TX_DONE = 1'b1;
            end
            if (TXEN && tx_auto) done_cnt = 3;
            if (force_done) begin
                TX_DONE = 1'b1;
                force_done = 1'b0;
            end
        end
    end

    // DAC monitor: checks data and period at each DAC_CLK rising edge.
    initial begin
        logic        prev_clk = 1'b0;
        int          last_rise = 0;
        logic [11:0] last_data = 12'd0;
        forever begin
            @(negedge CLK);
            if (DAC_CLK && !prev_clk && mon_mode != 0) begin
                rise_cnt++;
                if (mon_mode == 1 && dacq.size() != 0) chk("dac_seq", DAC_DATA, dacq.pop_front());
                if (!mon_fresh) begin
                    chk("dac_period", cyc - last_rise, exp_period);
                    if (mon_mode == 2) chk("dac_step", DAC_DATA, (last_data + 12'd1) & 12'h3FF);
                end
                mon_fresh = 1'b0;
                last_rise = cyc;
                last_data = DAC_DATA;
            end
            prev_clk = DAC_CLK;
        end
    end

    initial begin
        vec_t tbl[8];
        int   base;
        tbl[0] = '{8'h02, 1'b1, 8'h50, 1'b0, 1'b0};
        tbl[1] = '{8'h03, 1'b1, 8'hEE, 1'b0, 1'b0};
        tbl[2] = '{8'h05, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h0F, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'h74, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'h12, 1'b1, 8'h50, 1'b0, 1'b0};
        tbl[7] = '{8'h06, 1'b0, 8'h00, 1'b0, 1'b0};

        RST = 1'b1; RX_DONE = 1'b0; RX_DATA = 8'h00; TX_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        chk_reset("reset");
        RST = 1'b0;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].has_resp) txq.push_back(tbl[i].resp);
            send_byte(tbl[i].cmd);
            wait_drain(100, $sformatf("tbl%0d", i));
            repeat (10) @(negedge CLK);
            chk($sformatf("tbl%0d_playing", i), PLAYING, tbl[i].exp_play);
            chk($sformatf("tbl%0d_loaded", i), LOADED, tbl[i].exp_loaded);
        end

        do_load();
        txq.push_back(8'h52);
        send_byte(8'h02);
        wait_drain(100, "poll_loaded");
        repeat (10) @(negedge CLK);

        // Replay at divider 0: first rise still shows midscale, then 0..1023 and wrap.
        send_byte(8'h04);
        dacq.push_back(12'h800);
        for (int i = 0; i < 1024; i++) dacq.push_back(12'(i));
        dacq.push_back(12'h000);
        exp_period = 2; mon_fresh = 1'b1; mon_mode = 1;
        send_byte(8'h03);
        begin
            int k = 0;
            while (dacq.size() != 0 && k < 3000) begin
                @(negedge CLK);
                k++;
            end
        end
        mon_mode = 0;
        chk("replay_dac_pending", dacq.size(), 0);
        dacq.delete();
        chk("replay_playing", PLAYING, 1);
        txq.push_back(8'h53);
        send_byte(8'h02);
        wait_drain(100, "poll_playing");
        repeat (10) @(negedge CLK);

        // Divider 3 mid-play: 8-cycle DAC period, still one sample per period.
        send_byte(8'h34);
        repeat (20) @(negedge CLK);
        base = rise_cnt;
        exp_period = 8; mon_fresh = 1'b1; mon_mode = 2;
        repeat (100) @(negedge CLK);
        mon_mode = 0;
        chk("div_rises_ok", (rise_cnt - base) >= 12, 1);

        send_byte(8'h05);
        chk("stop_playing", PLAYING, 0);
        chk("stop_dacdata", DAC_DATA, 12'h800);
        repeat (20) @(negedge CLK);
        chk("stop_dacclk", DAC_CLK, 0);

        // LOAD during replay, then abandoned load hits the timeout.
        send_byte(8'h03);
        repeat (30) @(negedge CLK);
        chk("replay2_playing", PLAYING, 1);
        send_byte(8'h01);
        chk("loadstop_playing", PLAYING, 0);
        chk("loadstop_dacdata", DAC_DATA, 12'h800);
        chk("loadstop_loaded", LOADED, 0);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        txq.push_back(8'hEE);
        wait_drain(1000, "timeout");
        repeat (10) @(negedge CLK);
        chk("timeout_loaded", LOADED, 0);
        txq.push_back(8'hEE);
        send_byte(8'h03);
        wait_drain(100, "play_unloaded");
        repeat (10) @(negedge CLK);
        chk("play_unloaded_playing", PLAYING, 0);

        // Handshake: no TXEN while busy; commands dropped until TX_DONE.
        TX_VALID = 1'b1;
        txq.push_back(8'h50);
        base = tx_seen;
        send_byte(8'h02);
        repeat (50) @(negedge CLK);
        chk("hs_no_txen", tx_seen, base);
        chk("hs_pending", txq.size(), 1);
        tx_auto = 1'b0;
        TX_VALID = 1'b0;
        wait_drain(50, "hs_release");
        base = tx_seen;
        send_byte(8'h02);
        repeat (10) @(negedge CLK);
        chk("hs_drop_busy", tx_seen, base);
        @(posedge CLK);
        force_done = 1'b1;
        send_byte(8'h02);
        repeat (10) @(negedge CLK);
        chk("hs_drop_same_cycle", tx_seen, base);
        tx_auto = 1'b1;
        txq.push_back(8'h50);
        send_byte(8'h02);
        wait_drain(100, "hs_after_done");
        repeat (10) @(negedge CLK);

        // Reset in the middle of a held-off transmit.
        do_load();
        TX_VALID = 1'b1;
        base = tx_seen;
        send_byte(8'h02);
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset("midtx_reset");
        RST = 1'b0;
        TX_VALID = 1'b0;
        repeat (20) @(negedge CLK);
        chk("midtx_no_txen", tx_seen, base);
        txq.push_back(8'h50);
        send_byte(8'h02);
        wait_drain(100, "post_reset_poll");
        repeat (10) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
